logit_plan: RTL and testbench
=============================

LOGIT_PLAN -- requirements
Module: logit_plan

Interface
REQ-001 Parameter: N, 32, data width; Q(N/2).(N/2) two's-complement fixed point (Q16.16 at default).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 y  input  N  probability operand, Q16.16, nominal range (0,1).
REQ-005 in_valid  input  1  y is valid.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 x  output  N  inverse-PLAN (logit) result, Q16.16 signed.
REQ-008 sat  output  1  result was clamped to +/-5.0.
REQ-009 out_valid  output  1  x and sat are valid.
REQ-010 out_ready  input  1  consumer accepts the result.

Function
REQ-011 Exact inverse of the team's PLAN sigmoid segments; constants (hex, N=32): 0.5=0x00008000, 0.625=0x0000A000, 0.75=0x0000C000, 0.84375=0x0000D800, 0.921875=0x0000EC00, 1.0=0x00010000, 5.0=0x00050000.
REQ-012 Fold: if y >= 0.5, m = y and neg = 0; else m = 1.0 - y and neg = 1.
REQ-013 Segments on m: [0.5,0.75) -> |x| = (m-0.5)<<2; [0.75,0.921875) -> |x| = (m-0.625)<<3; [0.921875,1.0) -> |x| = (m-0.84375)<<5.
REQ-014 Saturation: signed y >= 1.0 -> x = +5.0; signed y <= 0 -> x = -5.0 (0xFFFB0000); sat = 1 in both cases, else sat = 0.
REQ-015 Sign: x = neg ? -|x| : |x|; y == 0.5 exactly yields x = 0, sat = 0.
REQ-016 Comparisons on y are signed; subtraction and shifts are N-bit with no overflow (|x| < 5.0 by construction). Results fall in [2.375,2.5) only through saturation: none; that gap is accepted.
REQ-017 FSM states: IDLE, FOLD, SEG, SIGN, DONE.
REQ-018 IDLE: in_ready = 1; in_valid = 1 registers y and moves to FOLD.
REQ-019 FOLD -> SEG -> SIGN, unconditional, one cycle each. FOLD computes m/neg/saturation class, SEG computes |x|, SIGN registers x and sat.
REQ-020 SIGN -> DONE. DONE: out_valid = 1; out_valid rises exactly 4 rising edges after the accepting edge.
REQ-021 DONE holds x, sat, out_valid stable until out_ready = 1, then returns to IDLE on that edge.
REQ-022 in_ready = 0 in every state except IDLE; no accept occurs in the cycle DONE completes; throughput is one result per 5 cycles minimum.
REQ-023 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Reset
REQ-024 rst_n low asynchronously forces state = IDLE, x = 0, sat = 0, out_valid = 0, and internal y/m/neg registers = 0.
REQ-025 in_ready = 1 from the first cycle after rst_n deasserts.
REQ-026 Reset mid-operation discards the in-flight operand; no out_valid pulse is produced for it.

Structure
REQ-027 Shared package logit_plan_pkg holds the FSM state encoding and all Q16.16 breakpoint, offset, and saturation constants from REQ-011.
REQ-028 One combinational sub-module plan_inv_seg (m in, |x| out) implements REQ-013 and is reusable by the sigmoid regression model.

Verification
REQ-029 y=0x00008000 -> x=0x00000000, sat=0, out_valid 4 edges after accept.
REQ-030 y=0x0000C000 -> x=0x00010000 (+1.0); y=0x00004000 -> x=0xFFFF0000 (-1.0); y=0x0000F000 -> x=0x00030000 (+3.0).
REQ-031 y=0x00010000 -> x=0x00050000, sat=1; y=0xFFFF0000 -> x=0xFFFB0000, sat=1.
REQ-032 Backpressure: out_ready held 0 for 10 cycles in DONE -> x/sat/out_valid stable and in_ready=0 throughout; one transfer on release; IDLE next cycle.
REQ-033 rst_n pulsed low during SEG -> out_valid and x at 0 immediately; no stale result; the next operand y=0x0000C000 yields 0x00010000.
REQ-034 Sweep y over 0x00000000..0x00010000 in steps of 0x100 against a reference model -> bit-exact x and sat; monotonic nondecreasing x.

Source files
------------

// File: rtl/logit_plan_pkg.sv
// Shared definitions for the PLAN-inverse (logit) datapath: FSM encoding and
// the Q16.16 breakpoint, offset and clamp constants.
package logit_plan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FOLD = 3'd1,
    ST_SEG  = 3'd2,
    ST_SIGN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int unsigned Q_FRAC = 16;

  localparam logic [31:0] Q_HALF     = 32'h0000_8000;  // 0.5
  localparam logic [31:0] Q_5_8      = 32'h0000_A000;  // 0.625
  localparam logic [31:0] Q_3_4      = 32'h0000_C000;  // 0.75
  localparam logic [31:0] Q_27_32    = 32'h0000_D800;  // 0.84375
  localparam logic [31:0] Q_59_64    = 32'h0000_EC00;  // 0.921875
  localparam logic [31:0] Q_ONE      = 32'h0001_0000;  // 1.0
  localparam logic [31:0] Q_FIVE     = 32'h0005_0000;  // 5.0

  // Rescale a Q16.16 constant to a format with 'frac' fractional bits.
  function automatic logic [63:0] q_scale(input logic [31:0] c, input int unsigned frac);
    logic [63:0] w;
    w = {32'h0000_0000, c};
    if (frac >= Q_FRAC) begin
      return w << (frac - Q_FRAC);
    end else begin
      return w >> (Q_FRAC - frac);
    end
  endfunction

endpackage

// File: rtl/logit_plan_if.sv
// Operand/result handshake bundle for logit_plan.
interface logit_plan_if #(
  parameter int N = 32
);
  logic [N-1:0] y;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic         sat;
  logic         out_valid;
  logic         out_ready;

  modport master (output y, in_valid, out_ready, input in_ready, x, sat, out_valid);
  modport slave  (input y, in_valid, out_ready, output in_ready, x, sat, out_valid);
endinterface

// File: rtl/plan_inv_seg.sv
// Combinational inverse of the three positive PLAN segments: maps a folded
// probability m in [0.5,1.0) to the logit magnitude |x|.
module plan_inv_seg
  import logit_plan_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] m,
  output logic [N-1:0] mag
);

  localparam logic [N-1:0] C_HALF  = N'(q_scale(Q_HALF,  N / 2));
  localparam logic [N-1:0] C_5_8   = N'(q_scale(Q_5_8,   N / 2));
  localparam logic [N-1:0] C_3_4   = N'(q_scale(Q_3_4,   N / 2));
  localparam logic [N-1:0] C_27_32 = N'(q_scale(Q_27_32, N / 2));
  localparam logic [N-1:0] C_59_64 = N'(q_scale(Q_59_64, N / 2));

  // Segment select and rescale; slopes 4, 8, 32 become left shifts.
  always_comb begin
    mag = '0;
    if ($signed(m) < $signed(C_3_4)) begin
      mag = (m - C_HALF) << 2'd2;
    end else if ($signed(m) < $signed(C_59_64)) begin
      mag = (m - C_5_8) << 2'd3;
    end else begin
      mag = (m - C_27_32) << 3'd5;
    end
  end

endmodule

// File: rtl/logit_plan.sv
// Multi-cycle logit (inverse PLAN sigmoid) unit: accept y, fold about 0.5,
// invert the segment, apply sign/clamp, hold the result until taken.
module logit_plan
  import logit_plan_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  logit_plan_if.slave  bus
);

  localparam logic [N-1:0] C_HALF = N'(q_scale(Q_HALF, N / 2));
  localparam logic [N-1:0] C_ONE  = N'(q_scale(Q_ONE,  N / 2));
  localparam logic [N-1:0] C_FIVE = N'(q_scale(Q_FIVE, N / 2));

  state_t       state_r;
  state_t       state_nx_s;
  logic [N-1:0] y_r;
  logic [N-1:0] m_r;
  logic         neg_r;
  logic         sat_pos_r;
  logic         sat_neg_r;
  logic [N-1:0] mag_r;
  logic [N-1:0] x_r;
  logic         sat_r;
  logic         in_ready_r;
  logic         out_valid_r;

  logic [N-1:0] m_s;
  logic         neg_s;
  logic         sat_pos_s;
  logic         sat_neg_s;
  logic [N-1:0] mag_s;
  logic [N-1:0] x_nx_s;
  logic         sat_nx_s;
  logic         in_ready_nx_s;
  logic         out_valid_nx_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: fixed four-cycle pipeline walk, then wait for the consumer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_nx_s = ST_FOLD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FOLD: state_nx_s = ST_SEG;
      ST_SEG:  state_nx_s = ST_SIGN;
      ST_SIGN: state_nx_s = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake flags come straight off flops.
  always_comb begin
    in_ready_nx_s  = 1'b0;
    out_valid_nx_s = 1'b0;
    case (state_nx_s)
      ST_IDLE: in_ready_nx_s  = 1'b1;
      ST_DONE: out_valid_nx_s = 1'b1;
      default: begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Fold about 0.5 and classify the clamp cases; all comparisons are signed.
  always_comb begin
    sat_pos_s = ($signed(y_r) >= $signed(C_ONE));
    sat_neg_s = ($signed(y_r) <= $signed({N{1'b0}}));
    if ($signed(y_r) >= $signed(C_HALF)) begin
      m_s   = y_r;
      neg_s = 1'b0;
    end else begin
      m_s   = C_ONE - y_r;
      neg_s = 1'b1;
    end
  end

  plan_inv_seg #(.N(N)) u_seg (
    .m   (m_r),
    .mag (mag_s)
  );

  // Sign restore; the clamp overrides whatever the segment produced.
  always_comb begin
    if (sat_pos_r) begin
      x_nx_s   = C_FIVE;
      sat_nx_s = 1'b1;
    end else if (sat_neg_r) begin
      x_nx_s   = -C_FIVE;
      sat_nx_s = 1'b1;
    end else begin
      x_nx_s   = neg_r ? -mag_r : mag_r;
      sat_nx_s = 1'b0;
    end
  end

  // Datapath and handshake registers, each stage loaded only in its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= '0;
      m_r         <= '0;
      neg_r       <= 1'b0;
      sat_pos_r   <= 1'b0;
      sat_neg_r   <= 1'b0;
      mag_r       <= '0;
      x_r         <= '0;
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            y_r <= bus.y;
          end
        end
        ST_FOLD: begin
          m_r       <= m_s;
          neg_r     <= neg_s;
          sat_pos_r <= sat_pos_s;
          sat_neg_r <= sat_neg_s;
        end
        ST_SEG:  mag_r <= mag_s;
        ST_SIGN: begin
          x_r   <= x_nx_s;
          sat_r <= sat_nx_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.x         = x_r;
  assign bus.sat       = sat_r;

endmodule

// File: tb/tb_logit_plan.sv
// Self-checking bench for logit_plan: directed vectors, backpressure, reset
// mid-operation, a full sweep and random operands against a real-valued model.
module tb_logit_plan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logit_plan_if #(.N(32)) bus ();

  logit_plan #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] y;
    logic [31:0] x;
    logic        s;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference computed in real arithmetic straight from the segment definitions.
  function automatic void ref_model(input logic [31:0] yv, output logic [31:0] xe, output logic se);
    real yr, m, ax;
    bit  neg;
    yr = $itor($signed(yv)) / 65536.0;
    if (yr >= 1.0) begin
      xe = 32'h0005_0000;
      se = 1'b1;
    end else if (yr <= 0.0) begin
      xe = 32'hFFFB_0000;
      se = 1'b1;
    end else begin
      neg = (yr < 0.5);
      m   = neg ? (1.0 - yr) : yr;
      if (m < 0.75)          ax = (m - 0.5) * 4.0;
      else if (m < 0.921875) ax = (m - 0.625) * 8.0;
      else                   ax = (m - 0.84375) * 32.0;
      if (neg) ax = -ax;
      xe = 32'($rtoi(ax * 65536.0));
      se = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [31:0] yv, input int hold, input bit early,
                        output logic [31:0] xo, output logic so);
    int w;
    int lat;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); @(negedge clk); w++;
    end
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.y         = yv;
    bus.in_valid  = 1'b1;
    bus.out_ready = early;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    bus.y        = 32'hDEAD_BEEF;
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    xo = bus.x;
    so = bus.sat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_x", bus.x, xo);
      chk("hold_sat", {31'd0, bus.sat}, {31'd0, so});
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] xo, xe, prev;
    logic        so, se;
    int          hold, vhigh;
    bit          early;

    vecs[0] = '{y: 32'h0000_8000, x: 32'h0000_0000, s: 1'b0};
    vecs[1] = '{y: 32'h0000_C000, x: 32'h0001_0000, s: 1'b0};
    vecs[2] = '{y: 32'h0000_4000, x: 32'hFFFF_0000, s: 1'b0};
    vecs[3] = '{y: 32'h0000_F000, x: 32'h0003_0000, s: 1'b0};
    vecs[4] = '{y: 32'h0001_0000, x: 32'h0005_0000, s: 1'b1};
    vecs[5] = '{y: 32'hFFFF_0000, x: 32'hFFFB_0000, s: 1'b1};
    vecs[6] = '{y: 32'h0000_EC00, x: 32'h0002_8000, s: 1'b0};
    vecs[7] = '{y: 32'h0000_1400, x: 32'hFFFD_8000, s: 1'b0};

    rst_n         = 1'b1;
    bus.y         = 32'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_x", bus.x, 32'd0);
    chk("reset_sat", {31'd0, bus.sat}, 32'd0);
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].y, (i == 3) ? 10 : 0, 1'b0, xo, so);
      chk("vec_x", xo, vecs[i].x);
      chk("vec_sat", {31'd0, so}, {31'd0, vecs[i].s});
    end

    // Reset while the operand sits in SEG; x holds a stale nonzero result here.
    bus.y        = 32'h0000_F000;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_x", bus.x, 32'd0);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vhigh = 0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (bus.out_valid === 1'b1) vhigh++;
    end
    chk("midrst_no_stale", 32'(vhigh), 32'd0);
    run_op(32'h0000_C000, 0, 1'b0, xo, so);
    chk("midrst_next_x", xo, 32'h0001_0000);

    prev = 32'h8000_0000;
    for (int i = 0; i <= 256; i++) begin
      run_op(32'(i * 256), 0, 1'b1, xo, so);
      ref_model(32'(i * 256), xe, se);
      chk("sweep_x", xo, xe);
      chk("sweep_sat", {31'd0, so}, {31'd0, se});
      chk("sweep_monotonic", {31'd0, ($signed(xo) >= $signed(prev))}, 32'd1);
      prev = xo;
    end

    for (int i = 0; i < 60; i++) begin
      logic [31:0] yv;
      yv    = (i % 8 == 7) ? $urandom() : 32'($urandom_range(32'h0001_0000, 0));
      hold  = $urandom_range(3, 0);
      early = (hold == 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      run_op(yv, hold, early, xo, so);
      ref_model(yv, xe, se);
      chk("rand_x", xo, xe);
      chk("rand_sat", {31'd0, so}, {31'd0, se});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
